// File: rtl/xbar_write_tracker.sv
// Master-side write tracker: per-ID outstanding counts with destination tags,
// plus a W-routing FIFO that steers W bursts in AW issue order.
module xbar_write_tracker #(
    parameter int ID_WIDTH        = 4,
    parameter int SLAVES          = 2,
    parameter int MAX_OUTSTANDING = 4,
    parameter int MAX_TOTAL       = 8,
    parameter int W_ROUTE_DEPTH   = 8,
    localparam int SLV_W = (SLAVES > 1) ? $clog2(SLAVES) : 1,
    localparam int TW    = $clog2(MAX_TOTAL + 1)
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    input  logic                aw_req_valid,
    input  logic [ID_WIDTH-1:0] aw_req_id,
    input  logic [SLV_W-1:0]    aw_req_dest,
    output logic                aw_block,
    input  logic                aw_issue,
    output logic                w_route_valid,
    output logic [SLV_W-1:0]    w_route_dest,
    input  logic                w_fire,
    input  logic                w_last,
    input  logic                b_fire,
    input  logic [ID_WIDTH-1:0] b_id,
    output logic [TW-1:0]       outstanding_total,
    output logic                err_unexpected_b
);

    localparam int NID = 1 << ID_WIDTH;
    localparam int CW  = $clog2(MAX_OUTSTANDING + 1);
    localparam int PW  = $clog2(W_ROUTE_DEPTH);
    localparam logic [CW-1:0] CNT_MAX = CW'(MAX_OUTSTANDING);
    localparam logic [TW-1:0] TOT_MAX = TW'(MAX_TOTAL);

    logic [CW-1:0]    cnt_q   [NID];
    logic [CW-1:0]    cnt_d   [NID];
    logic [SLV_W-1:0] tag_q   [NID];
    logic [SLV_W-1:0] tag_d   [NID];
    logic [SLV_W-1:0] route_q [W_ROUTE_DEPTH];
    logic [PW:0]      wr_q, wr_d;
    logic [PW:0]      rd_q, rd_d;
    logic [TW-1:0]    total_q, total_d;
    logic             err_q, err_d;

    logic fifo_full;
    logic fifo_empty;
    logic aw_cnt_busy;
    logic b_cnt_busy;
    logic issue;
    logic retire;
    logic pop;

    assign fifo_empty = (wr_q == rd_q);
    assign fifo_full  = (wr_q[PW] != rd_q[PW]) &&
                        (wr_q[PW-1:0] == rd_q[PW-1:0]);

    assign aw_cnt_busy = (cnt_q[aw_req_id] != '0);
    assign b_cnt_busy  = (cnt_q[b_id] != '0);

    // Same-ID writes to a different slave must wait until the ID drains.
    assign aw_block = ~aw_req_valid
                    | (cnt_q[aw_req_id] == CNT_MAX)
                    | (aw_cnt_busy & (tag_q[aw_req_id] != aw_req_dest))
                    | fifo_full
                    | (total_q == TOT_MAX);

    assign issue  = aw_issue & ~aw_block;
    assign retire = b_fire & b_cnt_busy;
    assign pop    = w_fire & w_last & ~fifo_empty;

    always_comb begin
        cnt_d   = cnt_q;
        tag_d   = tag_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        total_d = total_q;
        err_d   = err_q | (b_fire & ~b_cnt_busy);
        if (issue) begin
            cnt_d[aw_req_id] = cnt_d[aw_req_id] + CW'(1);
            tag_d[aw_req_id] = aw_req_dest;
            wr_d             = wr_q + (PW+1)'(1);
        end
        if (retire) begin
            cnt_d[b_id] = cnt_d[b_id] - CW'(1);
        end
        if (pop) begin
            rd_d = rd_q + (PW+1)'(1);
        end
        if (issue && !retire) begin
            total_d = total_q + TW'(1);
        end else if (retire && !issue) begin
            total_d = total_q - TW'(1);
        end
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            for (int i = 0; i < NID; i++) begin
                cnt_q[i] <= '0;
                tag_q[i] <= '0;
            end
            wr_q    <= '0;
            rd_q    <= '0;
            total_q <= '0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            tag_q   <= tag_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            total_q <= total_d;
            err_q   <= err_d;
        end
    end

    // Route storage needs no reset; visibility is governed by the pointers.
    always_ff @(posedge ACLK) begin
        if (issue) begin
            route_q[wr_q[PW-1:0]] <= aw_req_dest;
        end
    end

    assign w_route_valid     = ~fifo_empty;
    assign w_route_dest      = route_q[rd_q[PW-1:0]];
    assign outstanding_total = total_q;
    assign err_unexpected_b  = err_q;

endmodule

// File: tb/tb_xbar_write_tracker.sv
// Directed bench for xbar_write_tracker: a reference model of counts/tags
// and a scoreboard queue of expected W route destinations.
module tb_xbar_write_tracker;

    localparam int IDW   = 4;
    localparam int SLV_W = 1;
    localparam int TW    = 4;

    logic             ACLK = 1'b0;
    logic             ARESETn = 1'b0;
    logic             aw_req_valid = 1'b0;
    logic [IDW-1:0]   aw_req_id = '0;
    logic [SLV_W-1:0] aw_req_dest = '0;
    logic             aw_block;
    logic             aw_issue = 1'b0;
    logic             w_route_valid;
    logic [SLV_W-1:0] w_route_dest;
    logic             w_fire = 1'b0;
    logic             w_last = 1'b0;
    logic             b_fire = 1'b0;
    logic [IDW-1:0]   b_id = '0;
    logic [TW-1:0]    outstanding_total;
    logic             err_unexpected_b;

    xbar_write_tracker #(
        .ID_WIDTH(IDW),
        .SLAVES(2),
        .MAX_OUTSTANDING(4),
        .MAX_TOTAL(8),
        .W_ROUTE_DEPTH(8)
    ) dut (
        .ACLK(ACLK),
        .ARESETn(ARESETn),
        .aw_req_valid(aw_req_valid),
        .aw_req_id(aw_req_id),
        .aw_req_dest(aw_req_dest),
        .aw_block(aw_block),
        .aw_issue(aw_issue),
        .w_route_valid(w_route_valid),
        .w_route_dest(w_route_dest),
        .w_fire(w_fire),
        .w_last(w_last),
        .b_fire(b_fire),
        .b_id(b_id),
        .outstanding_total(outstanding_total),
        .err_unexpected_b(err_unexpected_b)
    );

    always #5 ACLK = ~ACLK;

    int n_checks = 0;
    int n_pass   = 0;

    int mcnt [16];
    int mtag [16];
    int mtotal = 0;
    bit merr = 1'b0;
    int sb [$];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic exp_block();
        int id;
        id = int'(aw_req_id);
        return !aw_req_valid || mcnt[id] == 4 ||
               (mcnt[id] != 0 && mtag[id] != int'(aw_req_dest)) ||
               sb.size() == 8 || mtotal == 8;
    endfunction

    task automatic idle_inputs();
        aw_req_valid = 1'b0;
        aw_issue     = 1'b0;
        w_fire       = 1'b0;
        w_last       = 1'b0;
        b_fire       = 1'b0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) begin
            mcnt[i] = 0;
            mtag[i] = 0;
        end
        mtotal = 0;
        merr   = 1'b0;
        sb.delete();
    endtask

    task automatic drive(input logic v, input int id, input int dest,
                         input logic iss, input logic wf, input logic wl,
                         input logic bf, input int bid);
        aw_req_valid = v;
        aw_req_id    = IDW'(id);
        aw_req_dest  = SLV_W'(dest);
        aw_issue     = iss;
        w_fire       = wf;
        w_last       = wl;
        b_fire       = bf;
        b_id         = IDW'(bid);
        #1;
        check("aw_block", {31'd0, aw_block}, {31'd0, exp_block()});
    endtask

    task automatic step();
        bit iss;
        bit ret;
        bit pop;
        int aid;
        int bid;
        iss = aw_issue && !exp_block();
        aid = int'(aw_req_id);
        bid = int'(b_id);
        ret = b_fire && mcnt[bid] != 0;
        if (b_fire && mcnt[bid] == 0) merr = 1'b1;
        pop = w_fire && w_last && sb.size() != 0;
        if (pop) void'(sb.pop_front());
        if (iss) begin
            sb.push_back(int'(aw_req_dest));
            mcnt[aid]++;
            mtag[aid] = int'(aw_req_dest);
        end
        if (ret) mcnt[bid]--;
        mtotal += int'(iss) - int'(ret);
        @(posedge ACLK);
        #1;
        idle_inputs();
        check("total", {28'd0, outstanding_total}, mtotal);
        check("route_valid", {31'd0, w_route_valid}, {31'd0, sb.size() != 0});
        if (sb.size() != 0)
            check("route_dest", {31'd0, w_route_dest}, sb[0]);
        check("err", {31'd0, err_unexpected_b}, {31'd0, merr});
    endtask

    task automatic do_reset();
        ARESETn = 1'b0;
        @(posedge ACLK);
        #1;
        ARESETn = 1'b1;
        idle_inputs();
        model_clear();
        check("rst_total", {28'd0, outstanding_total}, 0);
        check("rst_valid", {31'd0, w_route_valid}, 0);
        check("rst_err", {31'd0, err_unexpected_b}, 0);
        check("rst_block", {31'd0, aw_block}, 1);
    endtask

    task automatic iss_aw(input int id, input int dest);
        drive(1'b1, id, dest, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        step();
    endtask

    task automatic bresp(input int id);
        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, id);
        step();
    endtask

    task automatic wbeat(input logic last);
        drive(1'b0, 0, 0, 1'b0, 1'b1, last, 1'b0, 0);
        step();
    endtask

    initial begin
        model_clear();
        @(posedge ACLK);
        #1;
        do_reset();

        // Same-ID drain before switching destination
        iss_aw(3, 1);
        iss_aw(3, 1);
        iss_aw(3, 1);
        check("A_total3", {28'd0, outstanding_total}, 3);
        drive(1'b1, 3, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        check("A_block_dest", {31'd0, aw_block}, 1);
        step();
        check("A_total_hold", {28'd0, outstanding_total}, 3);
        bresp(3);
        bresp(3);
        drive(1'b1, 3, 0, 1'b0, 1'b0, 1'b0, 1'b1, 3);
        check("A_block_same_cyc", {31'd0, aw_block}, 1);
        step();
        drive(1'b1, 3, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        check("A_unblock", {31'd0, aw_block}, 0);
        step();
        check("A_total0", {28'd0, outstanding_total}, 0);
        wbeat(1'b1);
        wbeat(1'b1);
        wbeat(1'b1);
        check("A_drained", {31'd0, w_route_valid}, 0);

        // Per-ID outstanding limit
        for (int i = 0; i < 4; i++) iss_aw(5, 0);
        drive(1'b1, 5, 0, 1'b0, 1'b0, 1'b0, 1'b1, 5);
        check("B_block_max", {31'd0, aw_block}, 1);
        step();
        drive(1'b1, 5, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        check("B_unblock", {31'd0, aw_block}, 0);
        step();
        check("B_total4", {28'd0, outstanding_total}, 4);
        do_reset();

        // W routing order across bursts of 2, 1 and 3 beats
        iss_aw(0, 1);
        iss_aw(1, 0);
        iss_aw(2, 1);
        check("C_head0", {31'd0, w_route_dest}, 1);
        wbeat(1'b0);
        check("C_mid_burst", {31'd0, w_route_dest}, 1);
        wbeat(1'b1);
        check("C_head1", {31'd0, w_route_dest}, 0);
        wbeat(1'b1);
        check("C_head2", {31'd0, w_route_dest}, 1);
        wbeat(1'b0);
        wbeat(1'b0);
        check("C_last_pending", {31'd0, w_route_valid}, 1);
        wbeat(1'b1);
        check("C_empty", {31'd0, w_route_valid}, 0);
        wbeat(1'b1);
        bresp(0);
        bresp(1);
        bresp(2);
        check("C_total0", {28'd0, outstanding_total}, 0);

        // Route FIFO full, same-cycle pop+issue, pointer wrap
        for (int i = 8; i < 16; i++) iss_aw(i, 0);
        bresp(8);
        bresp(9);
        check("D_total6", {28'd0, outstanding_total}, 6);
        drive(1'b1, 4, 1, 1'b1, 1'b1, 1'b1, 1'b0, 0);
        check("D_block_full", {31'd0, aw_block}, 1);
        step();
        check("D_ignored", {28'd0, outstanding_total}, 6);
        drive(1'b1, 4, 1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        check("D_accept", {31'd0, aw_block}, 0);
        step();
        check("D_total7", {28'd0, outstanding_total}, 7);
        for (int i = 0; i < 7; i++) wbeat(1'b1);
        check("D_wrap_head", {31'd0, w_route_dest}, 1);
        check("D_wrap_valid", {31'd0, w_route_valid}, 1);
        wbeat(1'b1);
        check("D_wrap_empty", {31'd0, w_route_valid}, 0);
        iss_aw(3, 0);
        check("D_total8", {28'd0, outstanding_total}, 8);
        drive(1'b1, 2, 0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        check("D_block_total", {31'd0, aw_block}, 1);
        step();
        do_reset();

        // Simultaneous issue and retire on the same ID
        iss_aw(2, 0);
        drive(1'b1, 2, 0, 1'b1, 1'b0, 1'b0, 1'b1, 2);
        check("E_issue_ok", {31'd0, aw_block}, 0);
        step();
        check("E_total1", {28'd0, outstanding_total}, 1);
        drive(1'b1, 2, 1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        check("E_cnt_held", {31'd0, aw_block}, 1);
        step();
        bresp(2);
        check("E_total0", {28'd0, outstanding_total}, 0);
        drive(1'b1, 2, 1, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        check("E_drained", {31'd0, aw_block}, 0);
        step();

        // Unexpected B is sticky; reset mid-burst clears everything
        bresp(7);
        check("F_err", {31'd0, err_unexpected_b}, 1);
        check("F_total0", {28'd0, outstanding_total}, 0);
        drive(1'b0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        step();
        step();
        check("F_err_sticky", {31'd0, err_unexpected_b}, 1);
        iss_aw(7, 1);
        check("F_total1", {28'd0, outstanding_total}, 1);
        iss_aw(6, 0);
        wbeat(1'b0);
        drive(1'b0, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 7);
        do_reset();
        drive(1'b1, 7, 0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        check("F_post_rst", {31'd0, aw_block}, 0);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/xbar_write_tracker.md
Name: xbar_write_tracker

Overview:
Master-side write-transaction tracker for the crossbar. It replaces the single in-flight-write / one-bit-per-ID scheme with per-ID outstanding counters, a destination-slave tag per ID, and a W-routing FIFO. This lets one master port have several writes in flight, including several writes with the same ID, while AXI same-ID ordering is still preserved. It sits between the master AW/W/B FIFOs and the forward arbiters, and gates AW issue and W-beat routing.

Parameters:
ID_WIDTH, 4, AXI ID width; the table has 2**ID_WIDTH entries.
SLAVES, 2, number of crossbar slaves; SLV_W = max(1, $clog2(SLAVES)) is derived.
MAX_OUTSTANDING, 4, maximum in-flight writes per ID (>=1).
MAX_TOTAL, 8, maximum in-flight writes across all IDs (>=1).
W_ROUTE_DEPTH, 8, entries in the W-routing FIFO (power of two, >=2).

Ports:
ACLK  in  1  clock
ARESETn  in  1  synchronous active-low reset
aw_req_valid  in  1  AW at the head of the master AW FIFO
aw_req_id  in  ID_WIDTH  ID of the head AW
aw_req_dest  in  SLV_W  decoded destination slave of the head AW
aw_block  out  1  combinational; 1 = head AW must not be forwarded
aw_issue  in  1  head AW forwarded this cycle (arbiter grant & slave FIFO not full)
w_route_valid  out  1  a W route is available (route FIFO not empty)
w_route_dest  out  SLV_W  slave that the current W burst goes to
w_fire  in  1  W beat transferred this cycle
w_last  in  1  WLAST of the transferred beat
b_fire  in  1  B response accepted into the master B FIFO this cycle
b_id  in  ID_WIDTH  BID of that response
outstanding_total  out  $clog2(MAX_TOTAL+1)  writes in flight
err_unexpected_b  out  1  sticky; B arrived for an ID whose count is 0

Behaviour:
- Reset (ARESETn=0 at a posedge): all per-ID counts 0, dest tags 0, route FIFO empty, outstanding_total 0, err_unexpected_b 0. Reset mid-burst discards all state; no completion is emitted.
- Per-ID state: cnt[id] of width $clog2(MAX_OUTSTANDING+1), and tag[id] of width SLV_W.
- aw_block = ~aw_req_valid, OR any of the following:
  - cnt[aw_req_id]==MAX_OUTSTANDING
  - cnt[aw_req_id]!=0 and tag[aw_req_id]!=aw_req_dest (same-ID traffic to a different slave waits for drain)
  - route FIFO full
  - outstanding_total==MAX_TOTAL
- Blocking uses registered state only. A same-cycle retire or pop does not unblock until the next cycle.
- Valid issue = aw_issue & ~aw_block. aw_issue while blocked is ignored and changes no state.
- On a valid issue:
  - cnt[id]+1 and tag[id]<=aw_req_dest
  - push aw_req_dest into the route FIFO
  - outstanding_total+1
- Retire = b_fire & cnt[b_id]!=0: cnt[b_id]-1 and outstanding_total-1.
- b_fire with cnt[b_id]==0: set err_unexpected_b; counts are unchanged.
- Simultaneous issue and retire:
  - Same ID: cnt unchanged, tag updated.
  - Different IDs: each counter is updated independently.
  - outstanding_total: unchanged for a simultaneous valid issue and retire (any IDs); +1 if only an issue happens; -1 if only a retire happens.
- Route FIFO:
  - Registered; a pushed entry becomes visible 1 cycle after the issue.
  - w_route_dest = head entry; w_route_valid = ~empty.
  - Pop on w_fire & w_last & w_route_valid.
  - w_fire while ~w_route_valid is ignored.
  - Push and pop in the same cycle are both allowed, including when full (the pop frees a slot, but aw_block is still computed from the registered full flag).
  - Pointers are $clog2(W_ROUTE_DEPTH)+1 bits and wrap naturally; full/empty come from pointer MSB compare.
- A W burst may complete (pop) before its B returns. cnt is tied to B only, not to W.
- No output depends combinationally on w_fire, w_last, b_fire or b_id.

Test Plan:
- Reset, then issue id=3 dest=1 three times → cnt[3]=3, outstanding_total=3. The fourth issue with dest=0 → aw_block=1. After three b_fire id=3 → cnt[3]=0, and dest=0 is unblocked the next cycle.
- MAX_OUTSTANDING=4: issue id=5 four times to dest 0 → fifth request aw_block=1. A single b_fire id=5 → aw_block=0 one cycle later.
- Issue dests 1,0,1 on distinct IDs; drive W bursts of 2, 1 and 3 beats → w_route_dest sequence 1,0,1, pops exactly on each w_last, and w_route_valid=0 afterwards.
- Fill the route FIFO to 8 entries → aw_block=1. Same-cycle pop and aw_issue → issue ignored. The next cycle the issue is accepted and the pointer wrap is correct (head order is preserved).
- Same-cycle aw_issue id=2 and b_fire id=2 with cnt[2]=1 → cnt[2] stays 1, outstanding_total unchanged.
- b_fire id=7 with cnt[7]=0 → err_unexpected_b=1 and stays set until reset, counts unchanged. Assert ARESETn=0 mid-burst → all outputs return to reset values on the next posedge.
